// File: rtl/booth_r4_mul_seq.sv
// Iterative radix-4 Booth multiplier for the MULT/MULTU path.
// It retires DIGITS_PER_CYCLE Booth digits per clock and uses valid/ready handshakes on both sides.
module booth_r4_mul_seq #(
   parameter int WIDTH            = 32,
   parameter int DIGITS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int N_DIG = WIDTH / 2 + 1;
   localparam int C_CYC = (N_DIG + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
   localparam int AW    = 2 * WIDTH + 2;
   localparam int BQW   = 2 * C_CYC * DIGITS_PER_CYCLE + 1;
   localparam int CW    = $clog2(C_CYC + 1);
   localparam int SH    = 2 * DIGITS_PER_CYCLE;
   localparam logic [CW-1:0] C_LAST = CW'(C_CYC);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_r;
   logic [AW-1:0]        am_r;
   logic [BQW-1:0]       bq_r;
   logic [AW-1:0]        acc_r;
   logic [CW-1:0]        count_r;
   logic [2*WIDTH-1:0]   product_r;
   logic                 out_valid_r;
   logic                 in_ready_r;
   logic                 busy_r;
   logic [AW-1:0]        acc_next_s;
   logic [AW:0]          term_s;
   logic [AW-1:0]        a_ext_s;
   logic [BQW-1:0]       b_ext_s;

   // Returns {carry_in, term}: the term is the one's complement when the digit is negative.
   function automatic logic [AW:0] booth_term(input logic [2:0] sel, input logic [AW-1:0] a);
      logic [AW-1:0] mag;
      logic          neg;
      case (sel)
         3'b001, 3'b010: begin mag = a;                neg = 1'b0; end
         3'b011:         begin mag = a << 1;           neg = 1'b0; end
         3'b100:         begin mag = a << 1;           neg = 1'b1; end
         3'b101, 3'b110: begin mag = a;                neg = 1'b1; end
         default:        begin mag = {AW{1'b0}};       neg = 1'b0; end
      endcase
      return {neg, (neg ? ~mag : mag)};
   endfunction

   // Extends the operands straight to their working widths; bq carries an implicit B[-1]=0 at bit 0.
   always_comb begin
      a_ext_s = {{(AW - WIDTH){in_signed & multiplicand[WIDTH-1]}}, multiplicand};
      b_ext_s = {{(BQW - 1 - WIDTH){in_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};
   end

   // Accumulates the terms of this cycle's digit window; sign-filled digits past N-1 decode to 0.
   always_comb begin
      acc_next_s = acc_r;
      term_s     = {(AW + 1){1'b0}};
      for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
         term_s     = booth_term(bq_r[2*j +: 3], am_r << (2 * j));
         acc_next_s = acc_next_s + term_s[AW-1:0] + {{(AW - 1){1'b0}}, term_s[AW]};
      end
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         am_r        <= {AW{1'b0}};
         bq_r        <= {BQW{1'b0}};
         acc_r       <= {AW{1'b0}};
         count_r     <= {CW{1'b0}};
         product_r   <= {(2 * WIDTH){1'b0}};
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (!flush && in_valid) begin
                  am_r       <= a_ext_s;
                  bq_r       <= b_ext_s;
                  acc_r      <= {AW{1'b0}};
                  count_r    <= {CW{1'b0}};
                  state_r    <= S_CALC;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            S_CALC: begin
               if (flush) begin
                  state_r    <= S_IDLE;
                  in_ready_r <= 1'b1;
                  busy_r     <= 1'b0;
               end else if (count_r == C_LAST) begin
                  product_r   <= acc_r[2*WIDTH-1:0];
                  out_valid_r <= 1'b1;
                  state_r     <= S_DONE;
               end else begin
                  acc_r   <= acc_next_s;
                  am_r    <= am_r << SH;
                  bq_r    <= $unsigned($signed(bq_r) >>> SH);
                  count_r <= count_r + CW'(1);
               end
            end
            S_DONE: begin
               // The product register is kept on exit; only its valid flag drops.
               if (flush || out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= S_IDLE;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= S_IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign product   = product_r;
   assign busy      = busy_r;

endmodule
